xor_frame_checksum: RTL and testbench

Streaming XOR checksum engine: the parametrised, sequential successor to the single-bit XOR gate. Folds a frame of WIDTH-bit words into a running XOR over a valid/ready input stream, then presents one registered result per frame. In generate mode the result is the frame checksum; in check mode the frame carries its checksum as the final word, and a non-zero result flags an error. It sits between a word-stream producer and a framing or consumer stage.

---
 rtl/xor_pkg.sv | 12 +
 rtl/xor_word.sv | 12 +
 rtl/xor_frame_checksum.sv | 98 +++++++++
 tb/tb_xor_frame_checksum.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
// Shared types and constants for the streaming XOR checksum engine.
package xor_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/xor_word.sv
// Combinational WIDTH-bit vector XOR used for the accumulator next value.
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_frame_checksum.sv
// Folds a valid/ready word stream into a per-frame XOR checksum and presents
// one registered result per frame (generate or check mode, with overflow).
module xor_frame_checksum
  import xor_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_sum,
  output logic [LW-1:0]    m_len,
  output logic             m_err,
  output logic             m_ovf
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // s_ready and m_valid decode only the state register, so neither depends
  // combinationally on the opposite side of the block.

  state_e             state;
  state_e             state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_x;
  logic [LW-1:0]      cnt;
  logic [LW-1:0]      cnt_inc;
  logic               mode_q;
  logic               mode_eff;
  logic               beat;
  logic               overflow;
  logic               end_frame;
  logic               ovf_next;
  logic               err_next;

  xor_word #(.WIDTH(WIDTH)) u_acc_xor (
    .a (acc),
    .b (s_data),
    .y (acc_x)
  );

  assign s_ready   = (state == ACCUM);
  assign m_valid   = (state == HOLD);
  assign beat      = s_valid && s_ready;
  assign cnt_inc   = cnt + LW'(1);
  assign overflow  = (cnt_inc == LW'(MAX_LEN));
  assign end_frame = beat && (s_last || overflow);
  // The first beat's mode has not been registered yet, so use it directly.
  assign mode_eff  = (cnt == '0) ? mode : mode_q;
  assign ovf_next  = overflow && !s_last;
  assign err_next  = ovf_next || ((mode_eff == MODE_CHK) && (acc_x != '0));

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (end_frame) state_next = HOLD;
      HOLD:    if (m_ready)   state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      mode_q <= MODE_GEN;
      m_sum  <= '0;
      m_len  <= '0;
      m_err  <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      state <= state_next;
      if (beat) begin
        if (cnt == '0) mode_q <= mode;
        if (end_frame) begin
          acc   <= '0;
          cnt   <= '0;
          m_sum <= acc_x;
          m_len <= cnt_inc;
          m_ovf <= ovf_next;
          m_err <= err_next;
        end else begin
          acc <= acc_x;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum with WIDTH=8, MAX_LEN=4.
module tb_xor_frame_checksum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_sum;
  logic [LW-1:0]    m_len;
  logic             m_err;
  logic             m_ovf;

  int n_checks;
  int n_fail;

  xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sum   (m_sum),
    .m_len   (m_len),
    .m_err   (m_err),
    .m_ovf   (m_ovf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end just after a falling edge.
  task automatic send_beat(input logic [WIDTH-1:0] data, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!s_ready) begin
      n_fail++;
      $display("FAIL beat_accept: s_ready=%0b after %0d cycles, required 1", s_ready, n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ack_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_sum, m_len, m_err, m_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b sum=%h len=%0d err=%0b ovf=%0b, required all 0",
               m_valid, m_sum, m_len, m_err, m_ovf);
    end
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s_ready: got %0b required 1", s_ready);
    end
  endtask

  task automatic test_generate();
    mode = 1'b0;
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    send_beat(8'h56, 1'b1);
    // m_valid must already be high one cycle after the last handshake.
    n_checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gen_latency: got m_valid=%0b s_ready=%0b required 1/0", m_valid, s_ready);
    end
    n_checks++;
    if (m_sum !== 8'h70 || m_len !== 3'd3 || m_err !== 1'b0 || m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL gen_result: got sum=%h len=%0d err=%0b ovf=%0b required 70/3/0/0",
               m_sum, m_len, m_err, m_ovf);
    end
    ack_result();
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gen_release: got m_valid=%0b s_ready=%0b required 0/1", m_valid, s_ready);
    end
  endtask

  task automatic test_check();
    mode = 1'b1;
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    send_beat(8'h56, 1'b0);
    send_beat(8'h70, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h00 || m_len !== 3'd4 || m_err !== 1'b0 || m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_good: got v=%0b sum=%h len=%0d err=%0b ovf=%0b required 1/00/4/0/0",
               m_valid, m_sum, m_len, m_err, m_ovf);
    end
    ack_result();
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    send_beat(8'h56, 1'b0);
    send_beat(8'h71, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h01 || m_len !== 3'd4 || m_err !== 1'b1 || m_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_bad: got v=%0b sum=%h len=%0d err=%0b ovf=%0b required 1/01/4/1/0",
               m_valid, m_sum, m_len, m_err, m_ovf);
    end
    ack_result();
    mode = 1'b0;
  endtask

  task automatic test_single_hold();
    mode = 1'b0;
    // Idle cycles with junk on data/last must be ignored.
    for (int i = 0; i < 3; i++) begin
      s_data = 8'($urandom_range(0, 255));
      s_last = 1'b1;
      @(negedge clk);
    end
    send_beat(8'hA5, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'hA5 || m_len !== 3'd1 || m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got v=%0b sum=%h len=%0d err=%0b required 1/a5/1/0",
               m_valid, m_sum, m_len, m_err);
    end
    s_valid = 1'b1;
    s_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || m_sum !== 8'hA5 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%0b sum=%h s_ready=%0b required 1/a5/0",
                 i, m_valid, m_sum, s_ready);
      end
    end
    s_valid = 1'b0;
    ack_result();
    send_beat(8'h0F, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h0F || m_len !== 3'd1) begin
      n_fail++;
      $display("FAIL acc_cleared: got v=%0b sum=%h len=%0d required 1/0f/1", m_valid, m_sum, m_len);
    end
    ack_result();
  endtask

  task automatic test_overflow();
    mode = 1'b0;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h04, 1'b0);
    send_beat(8'h08, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h0F || m_len !== 3'd4 || m_ovf !== 1'b1 || m_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_result: got v=%0b sum=%h len=%0d ovf=%0b err=%0b required 1/0f/4/1/1",
               m_valid, m_sum, m_len, m_ovf, m_err);
    end
    s_valid = 1'b1;
    s_data  = 8'h10;
    s_last  = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_stall: got s_ready=%0b m_valid=%0b required 0/1", s_ready, m_valid);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_bubble: got s_ready=%0b m_valid=%0b required 1/0", s_ready, m_valid);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h10 || m_len !== 3'd1 || m_ovf !== 1'b0 || m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_next_frame: got v=%0b sum=%h len=%0d ovf=%0b err=%0b required 1/10/1/0/0",
               m_valid, m_sum, m_len, m_ovf, m_err);
    end
    ack_result();
  endtask

  task automatic test_reset_midframe();
    mode = 1'b0;
    send_beat(8'hFF, 1'b0);
    send_beat(8'h01, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({m_valid, m_sum, m_len, m_err, m_ovf} !== '0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%0b sum=%h len=%0d err=%0b ovf=%0b s_ready=%0b required 0s/1",
               m_valid, m_sum, m_len, m_err, m_ovf, s_ready);
    end
    send_beat(8'h3C, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h3C || m_len !== 3'd1) begin
      n_fail++;
      $display("FAIL midreset_frame: got v=%0b sum=%h len=%0d required 1/3c/1", m_valid, m_sum, m_len);
    end
    ack_result();
  endtask

  task automatic test_mode_change();
    mode = 1'b0;
    send_beat(8'h11, 1'b0);
    mode = 1'b1;
    send_beat(8'h22, 1'b1);
    n_checks++;
    if (m_valid !== 1'b1 || m_sum !== 8'h33 || m_len !== 3'd2 || m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_change: got v=%0b sum=%h len=%0d err=%0b required 1/33/2/0",
               m_valid, m_sum, m_len, m_err);
    end
    ack_result();
    mode = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_generate();
    test_check();
    test_single_hold();
    test_overflow();
    test_reset_midframe();
    test_mode_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
